// File: rtl/serial_paralelo_rx.sv
// Serial-to-parallel receiver: finds byte alignment on BC_LOCK consecutive COM characters, then strobes each non-COM byte.
// Latency: byte delivered (registered) on the edge sampling its LSB; no backpressure, one byte slot every 8 cycles.
module serial_paralelo_rx #(
    parameter logic [7:0] COM     = 8'hBC,
    parameter int         BC_LOCK = 4
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active
);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    localparam logic [2:0] LOCK_CNT = 3'(BC_LOCK);

    state_t     state_q, state_d;
    logic [7:0] sr_q, sr_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [2:0] bc_cnt_q, bc_cnt_d;
    logic [7:0] data_out_q, data_out_d;
    logic       valid_out_q, valid_out_d;
    logic       active_q, active_d;

    logic [7:0] cand;
    logic       is_com;
    logic       boundary;

    always_comb begin
        cand        = {sr_q[6:0], data_in};
        is_com      = (cand == COM);
        boundary    = (bit_cnt_q == 3'd7);

        sr_d        = cand;
        bit_cnt_d   = bit_cnt_q + 3'd1;
        bc_cnt_d    = bc_cnt_q;
        state_d     = state_q;
        data_out_d  = data_out_q;
        valid_out_d = 1'b0;
        active_d    = active_q;

        case (state_q)
            SEARCH: begin
                bit_cnt_d = 3'd0;
                if (is_com) begin
                    bc_cnt_d = 3'd1;
                    if (LOCK_CNT == 3'd1) begin
                        state_d  = ACTIVE;
                        active_d = 1'b1;
                    end else begin
                        state_d = ALIGN;
                    end
                end
            end
            ALIGN: begin
                if (boundary) begin
                    if (is_com && (bc_cnt_q + 3'd1 == LOCK_CNT)) begin
                        state_d  = ACTIVE;
                        active_d = 1'b1;
                        bc_cnt_d = LOCK_CNT;
                    end else if (is_com) begin
                        bc_cnt_d = bc_cnt_q + 3'd1;
                    end else begin
                        // Flush the failed byte so the hunt restarts on fresh bits only.
                        state_d  = SEARCH;
                        bc_cnt_d = 3'd0;
                        sr_d     = 8'h00;
                    end
                end
            end
            ACTIVE: begin
                if (boundary && !is_com) begin
                    data_out_d  = cand;
                    valid_out_d = 1'b1;
                end
            end
            default: begin
                state_d = SEARCH;
            end
        endcase
    end

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            state_q     <= SEARCH;
            sr_q        <= 8'h00;
            bit_cnt_q   <= 3'd0;
            bc_cnt_q    <= 3'd0;
            data_out_q  <= 8'h00;
            valid_out_q <= 1'b0;
            active_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            bit_cnt_q   <= bit_cnt_d;
            bc_cnt_q    <= bc_cnt_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
            active_q    <= active_d;
        end
    end

    assign data_out  = data_out_q;
    assign valid_out = valid_out_q;
    assign active    = active_q;

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// Bench for serial_paralelo_rx: directed bit streams, a bit-window reference model, and literal edge/data expectations.
module tb_serial_paralelo_rx;

    localparam int         LOCK = 4;
    localparam logic [7:0] BC   = 8'hBC;

    logic       clk_32f = 1'b0;
    logic       reset   = 1'b1;
    logic       data_in = 1'b0;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;

    always #5 clk_32f = ~clk_32f;

    serial_paralelo_rx #(.COM(BC), .BC_LOCK(LOCK)) dut (
        .clk_32f   (clk_32f),
        .reset     (reset),
        .data_in   (data_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .active    (active)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: window of the last 8 bits, count of bits since reset/failed lock,
    // and the edge number at which byte alignment was found.
    logic [7:0] m_win;
    int         m_fresh, m_mode, m_anchor, m_coms, m_n;
    logic [7:0] m_data;
    logic       m_valid, m_active;

    int         seg_edge;
    int         act_edge;
    int         p_edge[$];
    logic [7:0] p_dat[$];

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic checki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_step(input logic b, input logic r);
        m_valid = 1'b0;
        if (r) begin
            m_win = 8'h00; m_fresh = 0; m_mode = 0; m_coms = 0;
            m_data = 8'h00; m_active = 1'b0; m_n = 0; m_anchor = 0;
        end else begin
            m_n++;
            m_win = {m_win[6:0], b};
            if (m_fresh < 8) m_fresh++;
            if (m_mode == 0) begin
                if (m_fresh == 8 && m_win == BC) begin
                    m_anchor = m_n;
                    m_coms   = 1;
                    m_mode   = (m_coms == LOCK) ? 2 : 1;
                    m_active = (m_coms == LOCK);
                end
            end else if (((m_n - m_anchor) % 8) == 0) begin
                if (m_mode == 1) begin
                    if (m_win == BC) begin
                        m_coms++;
                        if (m_coms == LOCK) begin
                            m_mode   = 2;
                            m_active = 1'b1;
                        end
                    end else begin
                        m_mode  = 0;
                        m_coms  = 0;
                        m_fresh = 0;
                    end
                end else if (m_win != BC) begin
                    m_data  = m_win;
                    m_valid = 1'b1;
                end
            end
        end
    endtask

    task automatic seg_start();
        seg_edge = 0;
        act_edge = -1;
        p_edge.delete();
        p_dat.delete();
    endtask

    task automatic step(input logic b, input logic r);
        data_in = b;
        reset   = r;
        @(posedge clk_32f);
        model_step(b, r);
        seg_edge++;
        @(negedge clk_32f);
        check8("data_out", data_out, m_data);
        check1("valid_out", valid_out, m_valid);
        check1("active", active, m_active);
        if (active === 1'b1 && act_edge < 0) act_edge = seg_edge;
        if (valid_out === 1'b1) begin
            p_edge.push_back(seg_edge);
            p_dat.push_back(data_out);
        end
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) step(v[i], 1'b0);
    endtask

    task automatic send_coms(input int n);
        for (int k = 0; k < n; k++) send_byte(BC);
    endtask

    task automatic check_pulse(input string name, input int idx, input int e, input logic [7:0] d);
        if (idx < p_edge.size()) begin
            checki({name, "_edge"}, p_edge[idx], e);
            check8({name, "_data"}, p_dat[idx], d);
        end else begin
            checki({name, "_present"}, p_edge.size(), idx + 1);
        end
    endtask

    initial begin
        // Reset held with data toggling, then idle zeros
        seg_start();
        for (int i = 0; i < 3; i++) step(i[0], 1'b1);
        check8("rst_data", data_out, 8'h00);
        check1("rst_valid", valid_out, 1'b0);
        check1("rst_active", active, 1'b0);
        seg_start();
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0);
        checki("idle_no_active", act_edge, -1);

        // Lock and data
        step(1'b0, 1'b1);
        seg_start();
        send_coms(4);
        send_byte(8'hAA);
        send_byte(8'h55);
        checki("lock_edge", act_edge, 32);
        checki("lock_npulse", p_edge.size(), 2);
        check_pulse("lock_p0", 0, 40, 8'hAA);
        check_pulse("lock_p1", 1, 48, 8'h55);

        // Broken preamble
        step(1'b0, 1'b1);
        seg_start();
        send_coms(3);
        send_byte(8'h00);
        checki("broken_no_active", act_edge, -1);
        send_coms(4);
        send_byte(8'h12);
        checki("broken_lock_edge", act_edge, 64);
        checki("broken_npulse", p_edge.size(), 1);
        check_pulse("broken_p0", 0, 72, 8'h12);

        // Misaligned start
        step(1'b0, 1'b1);
        seg_start();
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        send_coms(4);
        send_byte(8'h3C);
        checki("mis_lock_edge", act_edge, 35);
        checki("mis_npulse", p_edge.size(), 1);
        check_pulse("mis_p0", 0, 43, 8'h3C);

        // COM filtering while active
        step(1'b0, 1'b1);
        seg_start();
        send_coms(4);
        send_byte(8'h11);
        send_byte(BC);
        check8("filt_hold", data_out, 8'h11);
        send_byte(8'h22);
        checki("filt_npulse", p_edge.size(), 2);
        check_pulse("filt_p0", 0, 40, 8'h11);
        check_pulse("filt_p1", 1, 56, 8'h22);

        // Reset in the middle of a byte, then full relock
        step(1'b0, 1'b1);
        seg_start();
        send_coms(4);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        check1("midrst_active", active, 1'b0);
        check1("midrst_valid", valid_out, 1'b0);
        checki("midrst_npulse", p_edge.size(), 0);
        seg_start();
        send_coms(4);
        send_byte(8'h77);
        checki("relock_edge", act_edge, 32);
        checki("relock_npulse", p_edge.size(), 1);
        check_pulse("relock_p0", 0, 40, 8'h77);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
